// File: rtl/chanctrl_regf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chanctrl_regf_pkg
// Brief    : Address map, ID value and soft-reset state encoding for the
//            channel-control register file.
// Revision : 1.0 - initial release
// ============================================================================
package chanctrl_regf_pkg;

  localparam int c_ADDR_ID       = 'h000;
  localparam int c_ADDR_GCTRL    = 'h001;
  localparam int c_ADDR_IRQ_EN   = 'h002;
  localparam int c_ADDR_IRQ_STAT = 'h003;
  localparam int c_ADDR_CH_BASE  = 'h010;

  localparam logic [15:0] c_ID_VALUE = 16'hC7A1;

  typedef enum logic [0:0] {
    SRST_IDLE   = 1'b0,
    SRST_ACTIVE = 1'b1
  } srst_state_t;

endpackage
`default_nettype wire

// File: rtl/chanctrl_regf_if.sv
`default_nettype none
// ============================================================================
// Module   : chanctrl_regf_if
// Brief    : Single-cycle memory-style register bus (strobe/addr/we/data).
// Revision : 1.0 - initial release
// ============================================================================
interface chanctrl_regf_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);

  logic              mem_ena_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic              mem_wena_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_err_o;

  modport master (
    output mem_ena_i, mem_addr_i, mem_wena_i, mem_wdata_i,
    input  mem_rdata_o, mem_err_o
  );

  modport slave (
    input  mem_ena_i, mem_addr_i, mem_wena_i, mem_wdata_i,
    output mem_rdata_o, mem_err_o
  );

endinterface
`default_nettype wire

// File: rtl/chanctrl_srst.sv
`default_nettype none
// ============================================================================
// Module   : chanctrl_srst
// Brief    : Soft-reset sequencer: IDLE/ACTIVE FSM with pulse-length counter.
// Revision : 1.0 - initial release
// ============================================================================
module chanctrl_srst
  import chanctrl_regf_pkg::*;
#(
  parameter int SRST_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_trig,
  input  wire logic i_ext,
  output logic      o_start,
  output logic      o_active
);

  srst_state_t r_state;
  logic [7:0]  r_cnt;
  logic        r_active;

  // Entry strobe is combinational so the register file clears on the same edge
  assign o_start  = (r_state == SRST_IDLE) && (i_trig || i_ext);
  assign o_active = r_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SRST_IDLE;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        SRST_IDLE: begin
          if (o_start) begin
            r_state  <= SRST_ACTIVE;
            r_cnt    <= 8'(SRST_CYCLES - 1);
            r_active <= 1'b1;
          end
        end
        SRST_ACTIVE: begin
          if (r_cnt == '0) begin
            if (!i_ext) begin
              r_state  <= SRST_IDLE;
              r_active <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state  <= SRST_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/chanctrl_regf.sv
`default_nettype none
// ============================================================================
// Module   : chanctrl_regf
// Brief    : Channel-control register file: bus decode, ENA/IRQ registers,
//            busy falling-edge interrupt and soft-reset sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module chanctrl_regf
  import chanctrl_regf_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32,
  parameter int SRST_CYCLES = 4
) (
  input  wire logic              main_clk_i,
  input  wire logic              main_rst_i,
  chanctrl_regf_if.slave         bus,
  output logic [NUM_CH-1:0]      regf_ch_ena_o,
  input  wire logic [NUM_CH-1:0] regf_ch_busy_i,
  input  wire logic              soft_rst_i,
  output logic                   soft_rst_o,
  output logic                   irq_o
);

  logic              w_acc, w_wr, w_rd;
  logic              w_hit_id, w_hit_gctrl, w_hit_irq_en, w_hit_irq_stat, w_hit_ch;
  logic              w_mapped, w_err, w_wr_ok, w_trig, w_start, w_active;
  logic [3:0]        w_idx;
  logic [NUM_CH-1:0] w_ch_sel, w_ch_ena_nxt, w_w1c, w_set;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_unused_wdata;

  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [NUM_CH-1:0] r_ch_ena, r_irq_en, r_irq_stat, r_busy_q;
  logic              r_irq;

  assign w_acc = bus.mem_ena_i;
  assign w_wr  = w_acc && bus.mem_wena_i;
  assign w_rd  = w_acc && !bus.mem_wena_i;
  assign w_idx = bus.mem_addr_i[3:0];

  assign w_hit_id       = bus.mem_addr_i == ADDR_W'(c_ADDR_ID);
  assign w_hit_gctrl    = bus.mem_addr_i == ADDR_W'(c_ADDR_GCTRL);
  assign w_hit_irq_en   = bus.mem_addr_i == ADDR_W'(c_ADDR_IRQ_EN);
  assign w_hit_irq_stat = bus.mem_addr_i == ADDR_W'(c_ADDR_IRQ_STAT);
  assign w_hit_ch       = (bus.mem_addr_i[ADDR_W-1:4] == (ADDR_W-4)'(c_ADDR_CH_BASE >> 4))
                       && ({1'b0, w_idx} < 5'(NUM_CH));
  assign w_mapped = w_hit_id || w_hit_gctrl || w_hit_irq_en || w_hit_irq_stat || w_hit_ch;

  // Writes are refused on ID and for the whole soft-reset pulse
  assign w_err   = w_acc && (!w_mapped || (w_wr && (w_hit_id || w_active)));
  assign w_wr_ok = w_wr && w_mapped && !w_hit_id && !w_active;
  assign w_trig  = w_wr_ok && w_hit_gctrl && bus.mem_wdata_i[0];

  assign w_w1c = (w_wr_ok && w_hit_irq_stat) ? bus.mem_wdata_i[NUM_CH-1:0] : '0;
  assign w_set = w_active ? '0 : (r_busy_q & ~regf_ch_busy_i);

  assign w_unused_wdata = &{1'b0, bus.mem_wdata_i};

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign w_ch_sel[n]     = w_hit_ch && (w_idx == 4'(n));
    assign w_ch_ena_nxt[n] = (w_wr_ok && w_ch_sel[n]) ? bus.mem_wdata_i[0] : r_ch_ena[n];
  end

  always_comb begin
    w_rd_val = '0;
    if (w_hit_id) begin
      w_rd_val[15:0] = c_ID_VALUE;
    end else if (w_hit_gctrl) begin
      w_rd_val[0] = w_active;
    end else if (w_hit_irq_en) begin
      w_rd_val[NUM_CH-1:0] = r_irq_en;
    end else if (w_hit_irq_stat) begin
      w_rd_val[NUM_CH-1:0] = r_irq_stat;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_ch_sel[n]) begin
          w_rd_val[0] = r_ch_ena[n];
          w_rd_val[1] = regf_ch_busy_i[n];
        end
      end
    end
  end

  chanctrl_srst #(
    .SRST_CYCLES (SRST_CYCLES)
  ) u_srst (
    .clk      (main_clk_i),
    .rst      (main_rst_i),
    .i_trig   (w_trig),
    .i_ext    (soft_rst_i),
    .o_start  (w_start),
    .o_active (w_active)
  );

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_busy_q   <= '0;
      r_ch_ena   <= '0;
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_rdata  <= (w_rd && w_mapped) ? w_rd_val : '0;
      r_err    <= w_err;
      r_busy_q <= regf_ch_busy_i;
      if (w_start) begin
        r_ch_ena   <= '0;
        r_irq_en   <= '0;
        r_irq_stat <= '0;
        r_irq      <= 1'b0;
      end else begin
        r_ch_ena <= w_ch_ena_nxt;
        if (w_wr_ok && w_hit_irq_en) begin
          r_irq_en <= bus.mem_wdata_i[NUM_CH-1:0];
        end
        // A set in the same cycle as its W1C clear survives
        r_irq_stat <= (r_irq_stat & ~w_w1c) | w_set;
        r_irq      <= |(r_irq_stat & r_irq_en);
      end
    end
  end

  assign bus.mem_rdata_o = r_rdata;
  assign bus.mem_err_o   = r_err;
  assign regf_ch_ena_o   = r_ch_ena;
  assign soft_rst_o      = w_active;
  assign irq_o           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_chanctrl_regf.sv
`default_nettype none
// ============================================================================
// Module   : tb_chanctrl_regf
// Brief    : Directed and random stimulus against a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chanctrl_regf;

  localparam int NUM_CH      = 4;
  localparam int ADDR_W      = 13;
  localparam int DATA_W      = 32;
  localparam int SRST_CYCLES = 4;
  localparam logic [31:0] c_ID_EXP = 32'h0000_C7A1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] busy = '0;
  logic [NUM_CH-1:0] ch_ena;
  logic              ext = 1'b0;
  logic              srst_o;
  logic              irq;

  int total = 0;
  int bad   = 0;
  int hi_cnt = 0;

  bit [NUM_CH-1:0] cur_b = '0;
  bit              cur_x = 1'b0;

  bit [NUM_CH-1:0] m_ena, m_ien, m_stat, m_bprev;
  bit              m_irq, m_on, m_err;
  int              m_left;
  bit [31:0]       m_rdata;

  chanctrl_regf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  chanctrl_regf #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .SRST_CYCLES (SRST_CYCLES)
  ) dut (
    .main_clk_i     (clk),
    .main_rst_i     (rst),
    .bus            (bus),
    .regf_ch_ena_o  (ch_ena),
    .regf_ch_busy_i (busy),
    .soft_rst_i     (ext),
    .soft_rst_o     (srst_o),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Next-state of the register file for one cycle, from the map rules
  task automatic model(input bit r, input bit e, input bit we, input int a,
                       input bit [31:0] wd, input bit [NUM_CH-1:0] b, input bit x);
    bit mapped, wok, start, nirq;
    bit [NUM_CH-1:0] clr, setb;
    bit [31:0] rv;
    if (r) begin
      m_ena = '0; m_ien = '0; m_stat = '0; m_bprev = '0;
      m_irq = 1'b0; m_on = 1'b0; m_left = 0; m_err = 1'b0; m_rdata = '0;
      return;
    end
    mapped = (a >= 0 && a <= 3) || (a >= 16 && a < 16 + NUM_CH);
    m_err  = e && (!mapped || (we && (a == 0 || m_on)));
    rv = '0;
    if (a == 0)       rv = c_ID_EXP;
    else if (a == 1)  rv = 32'(m_on);
    else if (a == 2)  rv = 32'(m_ien);
    else if (a == 3)  rv = 32'(m_stat);
    else if (mapped)  rv = 32'({b[a-16], m_ena[a-16]});
    m_rdata = (e && !we && mapped) ? rv : 32'h0;
    wok   = e && we && mapped && a != 0 && !m_on;
    start = !m_on && (x || (wok && a == 1 && wd[0]));
    nirq  = |(m_stat & m_ien);
    setb  = m_on ? '0 : (m_bprev & ~b);
    clr   = (wok && a == 3) ? wd[NUM_CH-1:0] : '0;
    m_bprev = b;
    if (start) begin
      m_on = 1'b1; m_left = SRST_CYCLES - 1;
      m_ena = '0; m_ien = '0; m_stat = '0; m_irq = 1'b0;
    end else begin
      if (wok && a == 2)  m_ien = wd[NUM_CH-1:0];
      if (wok && a >= 16) m_ena[a-16] = wd[0];
      m_stat = (m_stat & ~clr) | setb;
      m_irq  = nirq;
      if (m_on) begin
        if (m_left > 0) m_left--;
        else if (!x)    m_on = 1'b0;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit we, input int a,
                     input bit [31:0] wd, input bit [NUM_CH-1:0] b, input bit x);
    rst = r; bus.mem_ena_i = e; bus.mem_wena_i = we;
    bus.mem_addr_i = ADDR_W'(a); bus.mem_wdata_i = wd; busy = b; ext = x;
    model(r, e, we, a, wd, b, x);
    @(posedge clk);
    #1;
    if (srst_o) hi_cnt++;
    chk("rdata",    bus.mem_rdata_o,      m_rdata);
    chk("err",      32'(bus.mem_err_o),   32'(m_err));
    chk("ch_ena",   32'(ch_ena),          32'(m_ena));
    chk("irq",      32'(irq),             32'(m_irq));
    chk("soft_rst", 32'(srst_o),          32'(m_on));
  endtask

  task automatic wr(input int a, input bit [31:0] d);
    cyc(1'b0, 1'b1, 1'b1, a, d, cur_b, cur_x);
  endtask

  task automatic rd(input int a);
    cyc(1'b0, 1'b1, 1'b0, a, 32'h0, cur_b, cur_x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 32'h0, cur_b, cur_x);
  endtask

  initial begin
    int k, a;
    bit r, e, we;
    bit [31:0] wd;

    cyc(1'b1, 1'b0, 1'b0, 0, 32'h0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 2, 32'hF, '0, 1'b0);
    chk("reset_irq_en", 32'(dut.r_irq_en), 32'h0);

    // Channel enable write then readback with live busy
    cur_b = 4'b0100;
    wr('h12, 32'h1);
    chk("ena2_set", 32'(ch_ena), 32'h4);
    rd('h12);
    chk("ch2_read", bus.mem_rdata_o, 32'h3);
    cur_b = '0;
    idle(1);
    wr(3, 32'hF);

    // Busy falling edge raises IRQ_STAT then irq
    wr(2, 32'h2);
    cur_b = 4'b0010; idle(1);
    cur_b = '0;      idle(1);
    rd(3);
    chk("stat_after_fall", bus.mem_rdata_o, 32'h2);
    chk("irq_raised", 32'(irq), 32'h1);
    wr(3, 32'h2);
    idle(1);
    chk("irq_cleared", 32'(irq), 32'h0);

    // Clear and set collide: set wins
    cur_b = 4'b0010; idle(1);
    cur_b = '0;      wr(3, 32'h2);
    rd(3);
    chk("set_wins", bus.mem_rdata_o, 32'h2);

    // Bus-triggered soft reset, with a retrigger and a write inside the pulse
    wr(2, 32'hF);
    wr('h10, 32'h1);
    hi_cnt = 0;
    wr(1, 32'h1);
    chk("irq_off_on_entry", 32'(irq), 32'h0);
    wr(1, 32'h1);
    chk("srst_retrig_err", 32'(bus.mem_err_o), 32'h1);
    wr(2, 32'hF);
    chk("write_in_pulse_err", 32'(bus.mem_err_o), 32'h1);
    idle(4);
    chk("pulse_len", 32'(hi_cnt), 32'(SRST_CYCLES));
    rd(2);
    chk("irq_en_cleared", bus.mem_rdata_o, 32'h0);

    // Unmapped channel and ID write
    rd('h10 + NUM_CH);
    chk("unmapped_err", 32'(bus.mem_err_o), 32'h1);
    wr(0, 32'hFFFF);
    chk("id_write_err", 32'(bus.mem_err_o), 32'h1);
    rd(0);
    chk("id_value", bus.mem_rdata_o, c_ID_EXP);

    // External level request stretches the pulse; hard reset aborts it
    hi_cnt = 0;
    cur_x = 1'b1; idle(10);
    cur_x = 1'b0; idle(4);
    chk("ext_pulse_len", 32'(hi_cnt), 32'd10);
    cur_x = 1'b1; idle(3);
    cur_x = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1, 32'h1, cur_b, cur_x);
    chk("abort_srst", 32'(srst_o), 32'h0);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) cur_b = NUM_CH'($urandom);
      if ($urandom_range(0, 24) == 0) cur_x = ~cur_x;
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) != 0);
      k  = int'($urandom_range(0, 9));
      if (k <= 3)      a = k;
      else if (k <= 7) a = 16 + int'($urandom_range(0, NUM_CH));
      else if (k == 8) a = int'($urandom_range(0, 8191));
      else             a = int'($urandom_range(4, 15));
      wd = $urandom;
      if (a == 1 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      cyc(r, e, we, a, wd, cur_b, cur_x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chanctrl_regf.md
CHANCTRL_REGF -- requirements
Module: chanctrl_regf

Interface
REQ-001 Parameter NUM_CH, default 4, range 1..16: number of control channels.
REQ-002 Parameter ADDR_W, default 13: width of the word address.
REQ-003 Parameter DATA_W, default 32, minimum 16: width of the bus data.
REQ-004 Parameter SRST_CYCLES, default 4, range 1..255: soft-reset pulse length in cycles.
REQ-005 main_clk_i  in  1  clock; one clock domain only.
REQ-006 main_rst_i  in  1  reset; synchronous, active-high.
REQ-007 mem_ena_i  in  1  bus access strobe, one access per cycle.
REQ-008 mem_addr_i  in  ADDR_W  word address.
REQ-009 mem_wena_i  in  1  1 = write, 0 = read.
REQ-010 mem_wdata_i  in  DATA_W  write data.
REQ-011 mem_rdata_o  out  DATA_W  read data, registered.
REQ-012 mem_err_o  out  1  access error, registered.
REQ-013 regf_ch_ena_o  out  NUM_CH  per-channel enable; bus RW, core RO.
REQ-014 regf_ch_busy_i  in  NUM_CH  per-channel busy; core RW, bus RO, not stored in the register file.
REQ-015 soft_rst_i  in  1  external soft-reset request, level-sensitive.
REQ-016 soft_rst_o  out  1  soft-reset pulse to the core.
REQ-017 irq_o  out  1  interrupt, registered.

Function
REQ-018 The address map SHALL be: 0x000 ID (RO, constant); 0x001 GCTRL, where bit0 SRST is write-1-to-trigger and reads 1 while the sequence is active; 0x002 IRQ_EN, RW in bits [NUM_CH-1:0]; 0x003 IRQ_STAT, W1C in bits [NUM_CH-1:0]; 0x010+n CH_CTRL[n], where bit0 ENA is RW and bit1 BUSY is RO.
REQ-019 Unused bits SHALL read 0, and writes to unused bits SHALL be ignored without error.
REQ-020 A read accepted in cycle t SHALL present mem_rdata_o and mem_err_o in cycle t+1.
REQ-021 A write accepted in cycle t SHALL update the register in cycle t+1, and mem_err_o SHALL be valid in cycle t+1.
REQ-022 Without an access, mem_rdata_o and mem_err_o SHALL be 0 in the following cycle.
REQ-023 Any access to an unmapped address, including 0x010+n for n >= NUM_CH, SHALL give mem_err_o=1 and rdata 0 with no side effect.
REQ-024 A write to ID SHALL give mem_err_o=1 and SHALL have no effect.
REQ-025 A write to CH_CTRL that attempts to set BUSY SHALL NOT cause an error; BUSY SHALL be unaffected.
REQ-026 busy_q SHALL be a 1-cycle registered copy of regf_ch_busy_i.
REQ-027 A falling edge (busy_q=1, busy_i=0) SHALL set IRQ_STAT[n] in the next cycle.
REQ-028 IRQ_STAT bits SHALL be sticky until cleared by a W1C write.
REQ-029 If a W1C clear and a set of the same bit occur in the same cycle, set SHALL win.
REQ-030 irq_o SHALL be registered |(IRQ_STAT & IRQ_EN), so it follows IRQ_STAT and IRQ_EN by 1 cycle.
REQ-031 The soft-reset FSM states SHALL be IDLE and ACTIVE.
REQ-032 IDLE SHALL go to ACTIVE on an SRST=1 write or soft_rst_i=1, and the counter SHALL load SRST_CYCLES-1.
REQ-033 In ACTIVE, soft_rst_o SHALL be 1 and the counter SHALL decrement each cycle.
REQ-034 ACTIVE SHALL return to IDLE when the counter is 0 and soft_rst_i=0; while soft_rst_i=1 the counter SHALL hold at 0.
REQ-035 Entry to ACTIVE SHALL clear all ENA, IRQ_EN and IRQ_STAT bits, and irq_o SHALL be 0 in the next cycle.
REQ-036 While ACTIVE, bus writes SHALL be ignored with mem_err_o=1, and reads SHALL behave normally.
REQ-037 While ACTIVE, busy edges SHALL NOT set IRQ_STAT.
REQ-038 An SRST write while ACTIVE SHALL be ignored with an error and SHALL NOT restart the counter.

Reset
REQ-039 Under main_rst_i=1, every register SHALL go to 0 at the clock edge: all outputs 0, busy_q 0, FSM IDLE, counter 0.
REQ-040 main_rst_i asserted mid soft-reset SHALL abort the sequence, and soft_rst_o SHALL be 0 in the next cycle.
REQ-041 Reset SHALL take priority over every bus access in the same cycle.

Structure
REQ-042 Package chanctrl_regf_pkg SHALL hold the address constants, the ID value and the soft-reset FSM state enum.
REQ-043 Sub-module chanctrl_srst SHALL contain the FSM and the counter.
REQ-044 The top level SHALL contain the bus decode, the registers, the edge detection and the IRQ logic.

Verification
REQ-045 Write 0x1 to 0x012, then read 0x012 with busy_i[2]=1 -> ENA[2]=1 next cycle; rdata=0x3 one cycle after the read.
REQ-046 Drive busy_i[1] 1->0 with IRQ_EN=0x2 -> IRQ_STAT=0x2 one cycle later and irq_o=1 one cycle after that; then W1C 0x2 -> irq_o=0.
REQ-047 Issue a W1C of bit1 in the same cycle bit1 is set -> IRQ_STAT[1] remains 1.
REQ-048 Write GCTRL=1 with SRST_CYCLES=4 -> soft_rst_o high exactly 4 cycles; ENA/IRQ_EN/IRQ_STAT=0; a write during the pulse gives err=1.
REQ-049 Read 0x010+NUM_CH, then write ID -> err=1 on both, rdata=0, no register change.
REQ-050 Hold soft_rst_i high for 10 cycles -> soft_rst_o high 10 cycles; assert main_rst_i mid-pulse -> soft_rst_o=0 in the next cycle.
